// File: rtl/loop_nest_counter.sv
// Cascaded modulo counters forming a LEVELS-deep loop nest (level 0 innermost),
// with runtime limits, start/busy/done handshake, stall enable and synchronous abort.
module loop_nest_counter #(
  parameter int LEVELS = 3,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [LEVELS*CNT_W-1:0]   limits,
  input  logic                      en,
  output logic [LEVELS*CNT_W-1:0]   counts,
  output logic [LEVELS-1:0]         wrap,
  output logic                      busy,
  output logic                      last,
  output logic                      done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              done_q, done_d;
  logic [LEVELS-1:0] term;
  logic [LEVELS:0]   carry;
  logic              step;
  logic              load;
  logic              clear;

  assign step     = (state_q == RUN) & en & ~abort;
  assign load     = (state_q == IDLE) & start;
  assign clear    = (state_q == RUN) & abort;
  assign carry[0] = step;

  // A level advances when every inner level sits at its terminal count;
  // a level at its own terminal wraps to zero and passes the carry outward.
  for (genvar gi = 0; gi < LEVELS; gi++) begin : g_lvl
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lim_q, lim_d;

    assign term[gi]    = (cnt_q == lim_q);
    assign carry[gi+1] = carry[gi] & term[gi];
    assign counts[gi*CNT_W +: CNT_W] = cnt_q;

    always_comb begin
      cnt_d = cnt_q;
      lim_d = lim_q;
      if (load) begin
        cnt_d = '0;
        lim_d = limits[gi*CNT_W +: CNT_W];
      end else if (clear) begin
        cnt_d = '0;
      end else if (carry[gi]) begin
        cnt_d = term[gi] ? '0 : cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
        lim_q <= '0;
      end else begin
        cnt_q <= cnt_d;
        lim_q <= lim_d;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; carry[LEVELS] is a step taken on the final tuple
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (carry[LEVELS]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q == RUN);
    last = (state_q == RUN) & (&term);
    wrap = carry[LEVELS:1];
    done = done_q;
  end

endmodule

// File: tb/tb_loop_nest_counter.sv
// Directed self-checking bench for loop_nest_counter (LEVELS=3, CNT_W=8):
// a vector table for reset/handshake corners, then hand sequences for full runs.
module tb_loop_nest_counter;
  localparam int LEVELS = 3;
  localparam int CNT_W  = 8;
  localparam logic [23:0] LIM_A = 24'h020103;  // L2=2, L1=1, L0=3
  localparam logic [23:0] LIM_F = 24'hFFFFFF;
  localparam logic [23:0] LIM_Z = 24'h000000;
  localparam logic [23:0] LIM_D = 24'h0000FF;

  logic                    clk = 1'b0;
  logic                    rst, start, abort, en;
  logic [LEVELS*CNT_W-1:0] limits;
  logic [LEVELS*CNT_W-1:0] counts;
  logic [LEVELS-1:0]       wrap;
  logic                    busy, last, done;

  int n_cmp = 0;
  int n_bad = 0;

  loop_nest_counter #(.LEVELS(LEVELS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .limits(limits), .en(en),
    .counts(counts), .wrap(wrap), .busy(busy), .last(last), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, start, abort, en;
    logic [23:0] lim;
    logic [23:0] e_cnt;
    logic [2:0]  e_wrap;
    logic        e_busy, e_last, e_done;
  } vec_t;

  vec_t tbl [14];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 2 time units later.
  task automatic drive(input logic r, input logic s, input logic a, input logic e,
                       input logic [23:0] l);
    @(negedge clk);
    rst = r; start = s; abort = a; en = e; limits = l;
    #2;
  endtask

  task automatic check_out(input string tag, input logic [23:0] ec, input logic [2:0] ew,
                           input logic eb, input logic el, input logic ed);
    $display("%s: counts=%h wrap=%b busy=%b last=%b done=%b", tag, counts, wrap, busy, last, done);
    cmp({tag, ".counts"}, 32'(counts), 32'(ec));
    cmp({tag, ".wrap"},   32'(wrap),   32'(ew));
    cmp({tag, ".busy"},   32'(busy),   32'(eb));
    cmp({tag, ".last"},   32'(last),   32'(el));
    cmp({tag, ".done"},   32'(done),   32'(ed));
  endtask

  // Odometer tuple for step k of a {2,1,3} run
  function automatic logic [23:0] tup(input int k);
    logic [7:0] l0, l1, l2;
    l0 = 8'(k % 4);
    l1 = 8'((k / 4) % 2);
    l2 = 8'(k / 8);
    return {l2, l1, l0};
  endfunction

  function automatic logic [2:0] twrap(input int k);
    logic w0, w1, w2;
    w0 = (k % 4) == 3;
    w1 = w0 && ((k / 4) % 2) == 1;
    w2 = w1 && (k / 8) == 2;
    return {w2, w1, w0};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b1; abort = 1'b0; en = 1'b1; limits = LIM_A;

    //           rst   start abort en    lim    e_cnt      e_wrap  busy  last  done
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, LIM_A, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, LIM_A, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, LIM_A, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, LIM_A, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, LIM_Z, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, LIM_A, 24'h000000, 3'b000, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, LIM_A, 24'h000000, 3'b111, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, LIM_A, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, LIM_F, 24'h000000, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, LIM_F, 24'h000001, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, LIM_F, 24'h000002, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, LIM_F, 24'h000003, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, LIM_A, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, LIM_A, 24'h000000, 3'b000, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].start, tbl[i].abort, tbl[i].en, tbl[i].lim);
      check_out($sformatf("vec%0d", i), tbl[i].e_cnt, tbl[i].e_wrap,
                tbl[i].e_busy, tbl[i].e_last, tbl[i].e_done);
    end

    // Full nest with en held high, expectations from a nested loop
    begin
      int k;
      k = 0;
      for (int a2 = 0; a2 <= 2; a2++)
        for (int a1 = 0; a1 <= 1; a1++)
          for (int a0 = 0; a0 <= 3; a0++) begin
            logic [2:0] ew;
            ew[0] = (a0 == 3);
            ew[1] = ew[0] && (a1 == 1);
            ew[2] = ew[1] && (a2 == 2);
            drive(1'b0, 1'b0, 1'b0, 1'b1, LIM_A);
            check_out($sformatf("full%0d", k), {8'(a2), 8'(a1), 8'(a0)}, ew, 1'b1, ew[2], 1'b0);
            k++;
          end
    end
    // start on the done cycle launches the next run
    drive(1'b0, 1'b1, 1'b0, 0, LIM_A);
    check_out("full_done", 24'h0, 3'b000, 1'b0, 1'b0, 1'b1);

    // Stall every other cycle; limits input changed mid-run must not matter
    for (int k = 0; k < 24; k++) begin
      logic [23:0] l;
      l = (k >= 5) ? LIM_F : LIM_A;
      drive(1'b0, 1'b0, 1'b0, 1'b0, l);
      check_out($sformatf("stall%0d_hold", k), tup(k), 3'b000, 1'b1, k == 23, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, l);
      check_out($sformatf("stall%0d_step", k), tup(k), twrap(k), 1'b1, k == 23, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, LIM_A);
    check_out("stall_done", 24'h0, 3'b000, 1'b0, 1'b0, 1'b1);

    // Abort at (1,0,2) with en high, then immediate restart
    drive(1'b0, 1'b1, 1'b0, 1'b0, LIM_A);
    check_out("abort_idle", 24'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, LIM_A);
      check_out($sformatf("abrun%0d", k), tup(k), twrap(k), 1'b1, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1, LIM_A);
    check_out("abort_cyc", 24'h010002, 3'b000, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, LIM_D);
    check_out("abort_after", 24'h0, 3'b000, 1'b0, 1'b0, 1'b0);

    // L0=255, others 0: 256 steps
    for (int k = 0; k < 256; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, LIM_D);
      check_out($sformatf("deep%0d", k), 24'(k), (k == 255) ? 3'b111 : 3'b000,
                1'b1, k == 255, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, LIM_D);
    check_out("deep_done", 24'h0, 3'b000, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, LIM_D);
    check_out("deep_idle", 24'h0, 3'b000, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/loop_nest_counter.md
Name: loop_nest_counter

Overview:
- Parametrised successor to the single-level modulo counter: a chain of LEVELS cascaded modulo counters, like a nested for-loop.
- Runtime limits per level, a start/busy/done handshake, a stall enable, a synchronous abort, and per-level wrap strobes.
- Drives address/index generation for the conv, pool and dense layer engines. Level 0 is the innermost loop.

Parameters:
- LEVELS, 3, number of nested loop levels (>=1).
- CNT_W, 8, width of each level's counter and limit.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a new run; sampled only in IDLE.
- abort  input  1  synchronous cancel of a run in progress.
- limits  input  LEVELS*CNT_W  per-level terminal count; slice i = bits [i*CNT_W +: CNT_W]; level i counts 0..limits_i inclusive.
- en  input  1  advance one step when busy; low = stall (hold).
- counts  output  LEVELS*CNT_W  current index of every level, same slicing as limits.
- wrap  output  LEVELS  wrap[i]=1 when this step wraps level i.
- busy  output  1  run in progress.
- last  output  1  current counts are the final tuple of the run.
- done  output  1  one-cycle pulse after the final step is taken.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. rst dominates all other inputs.
- Reset state: FSM=IDLE; counts=0; limit registers=0; busy=0; done=0. Combinational outputs wrap and last are therefore 0.
- States: IDLE and RUN. busy = (state==RUN), registered.
- IDLE, start=1: latch limits into internal limit registers, force counts=0, enter RUN next cycle. en is ignored in IDLE, including when en and start are high in the same cycle.
- RUN, start=1: ignored. Limits are not re-sampled; changing the limits input mid-run has no effect.
- Per-level terminal: term[i] = (count_i == lim_i).
- Step: a step occurs when busy & en & !abort.
  - Level 0 increments on every step.
  - Level i>0 increments only when term[0..i-1] are all 1 (carry).
  - A level whose own term is 1 when it would increment wraps to 0 and propagates the carry.
- Wrap strobes (combinational): wrap[i] = busy & en & !abort & term[0] & ... & term[i].
- last (combinational) = busy & all term[i] = 1.
- Final step (step while last=1):
  - counts return to 0 and FSM goes to IDLE on the next edge.
  - done=1 for exactly that following cycle, registered.
  - wrap[LEVELS-1] is 1 in the final-step cycle.
- Run length: total steps = product over i of (lim_i + 1). With all limits 0 the run is one step: last=1 in the first RUN cycle.
- Stall: en=0 in RUN holds counts, and wrap stays 0. last may still be 1.
- abort in RUN: next edge gives counts=0, IDLE, done=0 (no pulse). If en is also high, no step is taken.
- abort in IDLE: no effect.
- start in the same cycle as done=1: accepted (the FSM is already IDLE), so runs can be issued back to back with one idle cycle.
- Arithmetic: per-level increment is CNT_W bits. With lim_i = 2^CNT_W - 1 the level reaches the all-ones value then wraps to 0 via term, with no overflow path.
- Intermediate counts never exceed the latched limit.
- No combinational path from start to any output.

Test Plan:
- Reset/idle: assert rst 2 cycles with start=1, en=1 -> counts=0, busy=0, done=0, wrap=0. Deassert; with start=0 the outputs stay unchanged.
- Full nest: LEVELS=3, CNT_W=8, limits={2,1,3} (L2=2, L1=1, L0=3), start then en held high:
  - 24 steps with counts visiting (0,0,0)..(2,1,3) in odometer order.
  - wrap[0] every 4th step; wrap[1] every 8th step; wrap[2] and last on step 24.
  - done pulse one cycle after step 24; busy low on that same cycle.
- Stall and limit change: same run, en toggled 1010... and limits changed to all-ones mid-run -> counts advance only on en=1 cycles. Sequence and length (24 steps) unchanged; wrap=0 on every en=0 cycle.
- Degenerate limits: limits all 0 -> last=1 in the first RUN cycle. One step, done pulse, back to IDLE. Limit L0=255 with others 0 -> 256 steps, count0 reaches 255, then wrap[0]=1 and done.
- Abort mid-run: abort at counts=(1,0,2) with en=1 -> next cycle counts=0, busy=0, no done pulse. Immediate restart works.
- Start collisions:
  - start pulsed while busy -> ignored, no re-latch.
  - start and en together in IDLE -> counts stay 0 in the first RUN cycle.
  - start asserted on the done cycle -> new run begins.
